// File: rtl/beta_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// beta_dmem_ctrl
//
// Data-memory controller sitting between the Beta core's data port and a
// word-addressed, handshaked memory bus.  Every core load/store is checked for
// word alignment, address range and conflicting enables.  A legal request runs
// exactly one bus transaction.  An illegal one is answered directly with a
// fault pulse and never reaches the bus.
//
// Optional feature (compile-time macro BETA_DMEM_TIMEOUT_EN):
//   When defined, a BUSY-cycle counter aborts a transaction that has not been
//   acknowledged after TIMEOUT cycles and reports it as a fault.  When not
//   defined, BUSY waits for bus_ack indefinitely.
//
// Handshake summary:
//   - request sampled in IDLE at edge N  -> bus_req high from cycle N+1
//   - bus_ack sampled at edge M          -> dataReady high during cycle M+1
//   - illegal request sampled at edge N  -> dataReady & dMemfault in cycle N+1
//   dataReady and dMemfault are flops and are never high two cycles in a row.
// -----------------------------------------------------------------------------
module beta_dmem_ctrl #(
    parameter int MEM_WORDS = 1024,     // words on the bus, power of two >= 4
    parameter int TIMEOUT   = 16,       // 1..255, BUSY cycles before abort
    localparam int ADDR_W   = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low

    // core data port
    input  logic [31:0]       DataAddress,
    input  logic [31:0]       DataWrite,
    input  logic              WriteEnable,
    input  logic              ReadEnable,
    output logic [31:0]       DataRead,
    output logic              dataReady,
    output logic              dMemfault,

    // memory bus
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for a core request
        BUSY  = 2'd1,   // bus transaction outstanding
        DONE  = 2'd2,   // completion pulse to the core
        FAULT = 2'd3    // fault pulse to the core, no bus activity
    } state_t;

    state_t state;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Request classification (purely combinational on the core inputs)
    // -------------------------------------------------------------------------
    logic req_any;
    logic misaligned;
    logic out_of_range;
    logic both_enables;
    logic req_fault;
    logic start_txn;
    logic timeout_hit;

    assign req_any      = ReadEnable | WriteEnable;
    assign misaligned   = |DataAddress[1:0];
    // Word index compared in 32 bits so MEM_WORDS up to 2**30 stays exact.
    assign out_of_range = ({2'b00, DataAddress[31:2]} >= 32'(MEM_WORDS));
    assign both_enables = ReadEnable & WriteEnable;
    assign req_fault    = misaligned | out_of_range | both_enables;

    // A legal request leaving IDLE; this is the only point where the core
    // inputs are captured, so later changes on them cannot disturb the bus.
    assign start_txn    = (state == IDLE) && req_any && !req_fault;

`ifdef BETA_DMEM_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // Watchdog on BUSY: counts BUSY cycles that pass without bus_ack.
    // -------------------------------------------------------------------------
    logic [7:0] busy_cnt;

    assign timeout_hit = (busy_cnt == 8'(TIMEOUT - 1));

    // Clear on entry to BUSY, count every unacknowledged BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= 8'd0;
        end else if (start_txn) begin
            busy_cnt <= 8'd0;
        end else if (state == BUSY && !bus_ack) begin
            busy_cnt <= busy_cnt + 8'd1;
        end
    end
`else
    // No watchdog: BUSY only ever leaves on bus_ack.
    assign timeout_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // Decide the next FSM state from the current state, request and bus_ack.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    state_next = req_fault ? FAULT : BUSY;
                end
            end
            BUSY: begin
                // An ack on the same edge as the timeout still completes normally.
                if (bus_ack) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = FAULT;
                end
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // Hold the FSM state; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments for all flop state so every register
            // samples pre-edge values regardless of block ordering.
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Core-side response flops
    // -------------------------------------------------------------------------
    // Registered completion/fault pulses, driven from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataReady <= 1'b0;
            dMemfault <= 1'b0;
        end else begin
            dataReady <= (state_next == DONE) || (state_next == FAULT);
            dMemfault <= (state_next == FAULT);
        end
    end

    // Load data: updated only by an acknowledged read, otherwise held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DataRead <= 32'd0;
        end else if (state == BUSY && bus_ack && !bus_we) begin
            DataRead <= bus_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Bus-side flops
    // -------------------------------------------------------------------------
    // bus_req is high exactly while the FSM sits in BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req <= 1'b0;
        end else begin
            bus_req <= (state_next == BUSY);
        end
    end

    // Capture address, direction and write data once, when a transaction starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= 32'd0;
        end else if (start_txn) begin
            bus_we    <= WriteEnable;
            bus_addr  <= DataAddress[ADDR_W+1:2];
            bus_wdata <= DataWrite;
        end
    end

endmodule

// File: tb/tb_beta_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_beta_dmem_ctrl
//
// Self-checking bench for beta_dmem_ctrl (MEM_WORDS = 1024, TIMEOUT = 4).
// A bus-slave memory answers transactions with a chosen number of wait
// states.  Expected results come from a reference model holding the memory
// contents as the core should see them, the expected last load value, and the
// latency/fault rules written directly as arithmetic on the request.
// Timeout scenarios are exercised when BETA_DMEM_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_beta_dmem_ctrl;

    localparam int MEM_WORDS = 1024;
    localparam int TIMEOUT   = 4;
    localparam int ADDR_W    = $clog2(MEM_WORDS);
    localparam int MAX_WAIT  = 200;

    logic              clk;
    logic              rst;
    logic [31:0]       DataAddress;
    logic [31:0]       DataWrite;
    logic              WriteEnable;
    logic              ReadEnable;
    logic [31:0]       DataRead;
    logic              dataReady;
    logic              dMemfault;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    beta_dmem_ctrl #(
        .MEM_WORDS (MEM_WORDS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .DataAddress (DataAddress),
        .DataWrite   (DataWrite),
        .WriteEnable (WriteEnable),
        .ReadEnable  (ReadEnable),
        .DataRead    (DataRead),
        .dataReady   (dataReady),
        .dMemfault   (dMemfault),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Bus-slave storage and the reference model's view of memory.
    logic [31:0] slave_mem [MEM_WORDS];
    logic [31:0] ref_mem   [MEM_WORDS];
    logic [31:0] exp_dread;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One core request, served by the bus slave after d wait states.
    // withdraw drops the core enables during BUSY, which must not abort anything.
    task automatic run_txn(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int d, input bit withdraw);
        bit          fault;
        bit          tmo;
        bit          done;
        bit          stable;
        int          lat;
        int          req_cycles;
        int          exp_lat;
        int          exp_req_cycles;
        logic [31:0] idx;
        logic [31:0] cap_addr;
        logic [31:0] cap_wdata;
        logic        cap_we;
        logic        got_fault;
        logic [31:0] got_dread;

        idx   = addr >> 2;
        fault = (addr[1:0] != 2'b00) || (idx >= MEM_WORDS) || (re && we);
        tmo   = 1'b0;
`ifdef BETA_DMEM_TIMEOUT_EN
        if (!fault && d >= TIMEOUT) tmo = 1'b1;
`endif
        exp_lat        = fault ? 1 : (tmo ? TIMEOUT + 1 : d + 2);
        exp_req_cycles = fault ? 0 : (tmo ? TIMEOUT : d + 1);

        @(negedge clk);
        bus_ack     = 1'b0;
        DataAddress = addr;
        DataWrite   = wdata;
        ReadEnable  = re;
        WriteEnable = we;

        done = 0; stable = 1; lat = 0; req_cycles = 0;
        cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
        got_fault = 1'b0; got_dread = '0;
        for (int c = 1; c <= MAX_WAIT && !done; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req) begin
                if (req_cycles == 0) begin
                    cap_addr  = 32'(bus_addr);
                    cap_wdata = bus_wdata;
                    cap_we    = bus_we;
                end else if (32'(bus_addr) != cap_addr || bus_wdata != cap_wdata || bus_we != cap_we) begin
                    stable = 0;
                end
                req_cycles++;
            end
            if (dataReady) begin
                lat         = c;
                done        = 1;
                got_fault   = dMemfault;
                got_dread   = DataRead;
                ReadEnable  = 1'b0;
                WriteEnable = 1'b0;
            end else begin
                if (withdraw && c == 2) begin
                    ReadEnable  = 1'b0;
                    WriteEnable = 1'b0;
                end
                if (bus_req && c == d + 1) begin
                    bus_ack = 1'b1;
                    if (bus_we) slave_mem[bus_addr] = bus_wdata;
                    else        bus_rdata = slave_mem[bus_addr];
                end else begin
                    bus_rdata = $urandom;
                end
            end
        end

        if (!done) begin
            check("ready_wait_expired", 32'(done), 32'd1);
        end else begin
            // Reference model update: only completed legal transactions count.
            if (!fault && !tmo) begin
                if (we) ref_mem[idx] = wdata;
                else    exp_dread = ref_mem[idx];
            end
            check("latency",    32'(lat),        32'(exp_lat));
            check("fault",      32'(got_fault),  32'(fault || tmo));
            check("req_cycles", 32'(req_cycles), 32'(exp_req_cycles));
            check("dataread",   got_dread,       exp_dread);
            if (!fault) begin
                check("bus_addr",   cap_addr,       idx);
                check("bus_we",     32'(cap_we),    32'(we));
                check("bus_stable", 32'(stable),    32'd1);
                if (we) check("bus_wdata", cap_wdata, wdata);
            end
        end

        // Pulses last exactly one cycle.
        @(negedge clk);
        check("ready_pulse", 32'(dataReady), 32'd0);
        check("fault_pulse", 32'(dMemfault), 32'd0);
    endtask

    // Idle cycles with stray bus_ack pulses, which must be ignored.
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(dataReady), 32'd0);
            check("idle_req",   32'(bus_req),   32'd0);
            bus_ack   = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
        end
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    // Reset pulled low in cycle 3 of a long write transaction.
    task automatic reset_mid_txn();
        @(negedge clk);
        DataAddress = 32'h0000_0020;
        DataWrite   = 32'h1234_5678;
        WriteEnable = 1'b1;
        ReadEnable  = 1'b0;
        bus_ack     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_bus_req",   32'(bus_req),   32'd0);
        check("rst_bus_we",    32'(bus_we),    32'd0);
        check("rst_bus_addr",  32'(bus_addr),  32'd0);
        check("rst_bus_wdata", bus_wdata,      32'd0);
        check("rst_dataread",  DataRead,       32'd0);
        check("rst_ready",     32'(dataReady), 32'd0);
        check("rst_fault",     32'(dMemfault), 32'd0);
        WriteEnable = 1'b0;
        exp_dread   = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_idle_req",   32'(bus_req),   32'd0);
        check("rst_idle_ready", 32'(dataReady), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          kind;
        int          d;
        logic        re;
        logic        we;

        for (int i = 0; i < MEM_WORDS; i++) begin
            slave_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
            ref_mem[i]   = slave_mem[i];
        end
        exp_dread   = 32'd0;
        rst         = 1'b0;
        DataAddress = '0;
        DataWrite   = '0;
        WriteEnable = 1'b0;
        ReadEnable  = 1'b0;
        bus_ack     = 1'b0;
        bus_rdata   = '0;

        repeat (2) @(negedge clk);
        check("reset_req",      32'(bus_req),   32'd0);
        check("reset_ready",    32'(dataReady), 32'd0);
        check("reset_fault",    32'(dMemfault), 32'd0);
        check("reset_dataread", DataRead,       32'd0);
        check("reset_addr",     32'(bus_addr),  32'd0);
        rst = 1'b1;

        // Directed scenarios.
        run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);   // write, 0 waits
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0,         0, 0);   // read back
        run_txn(1'b1, 1'b0, 32'h0000_0006, 32'h0,         0, 0);   // misaligned
        run_txn(1'b0, 1'b1, 32'h0000_1000, 32'h1111_2222, 0, 0);   // out of range
        run_txn(1'b1, 1'b1, 32'h0000_0040, 32'h3333_4444, 0, 0);   // both enables
        run_txn(1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 0);   // last legal word
        run_txn(1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         3, 1);   // read it, withdrawn
`ifndef BETA_DMEM_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0,         5, 0);   // 5 wait states
`else
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0,         3, 0);   // ack on 4th cycle
        run_txn(1'b0, 1'b1, 32'h0000_0080, 32'h7777_0000, 99, 0);  // no ack: timeout
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0,         TIMEOUT, 0);
`endif
        reset_mid_txn();
        run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0,         1, 0);   // write was abandoned

        // Randomized traffic, back-to-back and with gaps.
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 9);
            a    = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 31)) << 2
                                               : 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            re   = $urandom_range(0, 1) != 0;
            we   = !re;
            case (kind)
                0:       a = a | 32'($urandom_range(1, 3));
                1:       a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
                2:       begin re = 1'b1; we = 1'b1; end
                default: ;
            endcase
`ifdef BETA_DMEM_TIMEOUT_EN
            d = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 7);
`else
            d = $urandom_range(0, 6);
`endif
            run_txn(re, we, a, $urandom, d, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/beta_dmem_ctrl.md
# beta_dmem_ctrl

Data-memory controller between the Beta core's data port and a word-addressed, handshaked memory bus. It accepts the core's ReadEnable/WriteEnable requests, checks each request for alignment and range, and runs one bus transaction per legal request. It returns read data, dataReady and dMemfault to the core, replacing the constant dataReady=1 / dMemfault=0 tie-offs at the Beta top level.

## Interface
Parameters:
- MEM_WORDS, 1024: number of 32-bit words on the bus; power of two ≥ 4; ADDR_W = clog2(MEM_WORDS).
- TIMEOUT, 16: maximum BUSY cycles without bus_ack (1..255); used only with BETA_DMEM_TIMEOUT_EN.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- DataAddress  in  32  core byte address.
- DataWrite  in  32  core store data.
- WriteEnable  in  1  core store request; held until dataReady.
- ReadEnable  in  1  core load request; held until dataReady.
- DataRead  out  32  registered load data.
- dataReady  out  1  one-cycle completion pulse.
- dMemfault  out  1  one-cycle fault pulse, coincident with dataReady.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word address.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data, valid when bus_ack = 1.
- bus_ack  in  1  transaction accept/complete, one cycle.

## Operation
States: IDLE, BUSY, DONE, FAULT.

IDLE:
- No request: stay.
- Request present (ReadEnable or WriteEnable) with a fault condition: go to FAULT. Fault conditions are DataAddress[1:0] ≠ 0; DataAddress[31:2] ≥ MEM_WORDS; or ReadEnable and WriteEnable both high.
- Legal request: latch bus_addr = DataAddress[ADDR_W+1:2], bus_wdata = DataWrite, bus_we = WriteEnable; set bus_req = 1; go to BUSY.

BUSY:
- bus_req, bus_addr, bus_wdata and bus_we stay stable.
- The core request is not re-sampled. A withdrawn request does not abort the transaction.
- bus_ack = 1: clear bus_req. For a read, DataRead ← bus_rdata. Go to DONE.
- For a write, DataRead keeps its previous value.

DONE: dataReady = 1, dMemfault = 0; go to IDLE.

FAULT: dataReady = 1, dMemfault = 1; go to IDLE. No bus transaction is issued, and DataRead is unchanged.

Back-to-back requests: a request held in the cycle after DONE or FAULT is treated as a new request.

## Timing
- Reset (rst = 0) acts immediately: state = IDLE, and bus_req, bus_we, bus_addr, bus_wdata, DataRead, dataReady and dMemfault are all 0.
- Reset in mid-transaction abandons the transaction; bus_req falls asynchronously.
- Request sampled in IDLE at edge N: bus_req is high from cycle N+1.
- bus_ack sampled at edge M: dataReady is high during cycle M+1.
- Minimum latency, with the request in cycle 0 and bus_ack in cycle 1: dataReady in cycle 2.
- Fault latency: the request is sampled at edge N and dataReady with dMemfault is high in cycle N+1.
- dataReady and dMemfault are registered and never high for more than one consecutive cycle.
- bus_ack outside BUSY is ignored.

## Configuration
- BETA_DMEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments on each BUSY cycle without bus_ack.
  - At the edge where the count equals TIMEOUT−1 and bus_ack = 0: clear bus_req, go to FAULT.
  - If bus_ack = 1 on that same edge, the ack wins and the next state is DONE.
- BETA_DMEM_TIMEOUT_EN undefined: no counter; BUSY waits for bus_ack indefinitely.

## Test plan
- Write then read, with MEM_WORDS = 1024:
  - Stimulus: WriteEnable, DataAddress = 0x0000_0010, DataWrite = 0xDEAD_BEEF, bus_ack after 0 wait cycles.
  - Required: bus_addr = 4, bus_we = 1, dataReady in cycle 2, dMemfault = 0.
  - Then ReadEnable to the same address with bus_rdata = 0xDEAD_BEEF: required DataRead = 0xDEAD_BEEF with dataReady.
- Misaligned address: ReadEnable, DataAddress = 0x0000_0006 -> no bus_req ever; dataReady = dMemfault = 1 in cycle 1 only.
- Out of range, MEM_WORDS = 1024: WriteEnable, DataAddress = 0x0000_1000 -> fault pulse, no bus_req.
- Both enables high at a legal address -> fault pulse, no bus_req.
- Wait states and reset:
  - Stimulus: bus_ack delayed 5 cycles. Required: bus_req and bus_addr held stable for 5 cycles; dataReady the cycle after ack.
  - Repeat with rst pulled low in cycle 3. Required: bus_req = 0 immediately, all outputs 0, state IDLE.
- Timeout, with BETA_DMEM_TIMEOUT_EN defined and TIMEOUT = 4:
  - bus_ack never asserted -> bus_req high for 4 cycles, then a dMemfault/dataReady pulse.
  - bus_ack on the 4th cycle -> normal DONE with dMemfault = 0.
